// File: rtl/axis_upsizer.sv
// axis_upsizer
//   AXI-Stream width up-converter. Packs RATIO consecutive narrow slave beats
//   into one wide master beat. A slave tlast closes a partial word early. Lanes
//   that hold no slave beat are zero in m_tdata and cleared in m_tkeep.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   s_tdata/tlast/tvalid/tready   narrow slave stream (AXIS_DWIDTH bits)
//   m_tdata/tkeep/tlast/tvalid/tready  wide master stream (AXIS_DWIDTH*RATIO bits)
//     lane i of m_tdata is bits [(i+1)*AXIS_DWIDTH-1 : i*AXIS_DWIDTH]
//
// s_tready is combinational from the master register state and m_tready. The
// downstream skid buffer registers that path.
module axis_upsizer #(
  parameter int AXIS_DWIDTH = 8,
  parameter int RATIO       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXIS_DWIDTH-1:0]       s_tdata,
  input  logic                         s_tlast,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  output logic [AXIS_DWIDTH*RATIO-1:0] m_tdata,
  output logic [RATIO-1:0]             m_tkeep,
  output logic                         m_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready
);

  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int MW    = AXIS_DWIDTH * RATIO;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [MW-1:0]    acc_data_r;
  logic [RATIO-1:0] acc_keep_r;

  logic [MW-1:0]    m_tdata_r;
  logic [RATIO-1:0] m_tkeep_r;
  logic             m_tlast_r;
  logic             m_tvalid_r;

  logic             m_active_s;
  logic             accept_s;
  logic             close_s;
  logic             m_hs_s;
  logic [MW-1:0]    merged_data_s;
  logic [RATIO-1:0] merged_keep_s;

  // The output register can take a new word when it is empty or being drained.
  assign m_active_s = ~m_tvalid_r | m_tready;
  assign s_tready   = m_active_s & ~rst;
  assign accept_s   = s_tvalid & s_tready;
  assign close_s    = accept_s & ((cnt_r == LAST_LANE) | s_tlast);
  assign m_hs_s     = m_tvalid_r & m_tready;

  assign m_tdata  = m_tdata_r;
  assign m_tkeep  = m_tkeep_r;
  assign m_tlast  = m_tlast_r;
  assign m_tvalid = m_tvalid_r;

  // Accumulator with the current slave beat dropped into lane cnt. Lanes above
  // cnt are always zero in the accumulator, so a closing word is zero-padded.
  always_comb begin
    merged_data_s = acc_data_r;
    merged_keep_s = acc_keep_r;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_r == CNT_W'(i)) begin
        merged_data_s[i*AXIS_DWIDTH +: AXIS_DWIDTH] = s_tdata;
        merged_keep_s[i]                            = 1'b1;
      end else begin
        merged_data_s[i*AXIS_DWIDTH +: AXIS_DWIDTH] = acc_data_r[i*AXIS_DWIDTH +: AXIS_DWIDTH];
        merged_keep_s[i]                            = acc_keep_r[i];
      end
    end
  end

  // Lane counter and accumulator: grow on each accept, clear when a word closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_data_r <= {MW{1'b0}};
      acc_keep_r <= {RATIO{1'b0}};
    end else if (accept_s) begin
      if (close_s) begin
        cnt_r      <= {CNT_W{1'b0}};
        acc_data_r <= {MW{1'b0}};
        acc_keep_r <= {RATIO{1'b0}};
      end else begin
        cnt_r      <= cnt_r + CNT_W'(1);
        acc_data_r <= merged_data_s;
        acc_keep_r <= merged_keep_s;
      end
    end
  end

  // Master output register: load on close (even while draining), else drop
  // valid once the held word is taken. Stalls leave everything untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata_r  <= {MW{1'b0}};
      m_tkeep_r  <= {RATIO{1'b0}};
      m_tlast_r  <= 1'b0;
      m_tvalid_r <= 1'b0;
    end else if (close_s) begin
      m_tdata_r  <= merged_data_s;
      m_tkeep_r  <= merged_keep_s;
      m_tlast_r  <= s_tlast;
      m_tvalid_r <= 1'b1;
    end else if (m_hs_s) begin
      m_tlast_r  <= 1'b0;
      m_tvalid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_upsizer.sv
// Testbench for axis_upsizer (AXIS_DWIDTH=8, RATIO=4). Directed steps followed
// by a random-stall soak; a queue-based packing model predicts every master beat.
module tb_axis_upsizer;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int W  = DW * R;

  typedef struct {
    logic [W-1:0] data;
    logic [R-1:0] keep;
    logic         last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic [R-1:0]  m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;

  int tests;
  int fails;

  beat_t         exp_q[$];   // words the model says are closed but not yet taken
  beat_t         obs_q[$];   // words actually taken from the DUT
  logic [DW-1:0] grp[$];     // slave bytes of the word being packed
  logic [DW-1:0] in_bytes[$];
  logic          in_last[$];
  logic          last_accept;
  logic          prev_rst;
  int            stalls;

  axis_upsizer #(.AXIS_DWIDTH(DW), .RATIO(R)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check and advance the model just after.
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic l, input logic mr);
    logic  pend;
    logic  exp_rdy;
    beat_t b;
    beat_t o;
    @(negedge clk);
    rst = r; s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = mr;
    #1;
    pend = (exp_q.size() != 0);
    check("m_tvalid", 64'(m_tvalid), 64'(pend));
    check("last_implies_valid", 64'(m_tlast & ~m_tvalid), 64'd0);
    if (prev_rst) begin
      check("rst_m_tdata", 64'(m_tdata), 64'd0);
      check("rst_m_tkeep", 64'(m_tkeep), 64'd0);
      check("rst_m_tlast", 64'(m_tlast), 64'd0);
    end
    if (pend && m_tvalid) begin
      check("m_tdata", 64'(m_tdata), 64'(exp_q[0].data));
      check("m_tkeep", 64'(m_tkeep), 64'(exp_q[0].keep));
      check("m_tlast", 64'(m_tlast), 64'(exp_q[0].last));
    end
    exp_rdy = (!pend || mr) && !r;
    check("s_tready", 64'(s_tready), 64'(exp_rdy));
    if (v && !s_tready) stalls++;
    last_accept = 1'b0;
    if (r) begin
      exp_q.delete();
      grp.delete();
    end else begin
      if (pend && mr) begin
        o.data = m_tdata; o.keep = m_tkeep; o.last = m_tlast;
        obs_q.push_back(o);
        void'(exp_q.pop_front());
      end
      if (v && exp_rdy) begin
        last_accept = 1'b1;
        grp.push_back(d);
        in_bytes.push_back(d);
        in_last.push_back(l);
        if (grp.size() == R || l) begin
          b.data = {W{1'b0}};
          for (int i = 0; i < grp.size(); i++) b.data[i*DW +: DW] = grp[i];
          b.keep = R'((1 << grp.size()) - 1);
          b.last = l;
          exp_q.push_back(b);
          grp.delete();
        end
      end
    end
    prev_rst = r;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input logic mr);
    int tries;
    tries = 0;
    do begin
      step(1'b0, 1'b1, d, l, mr);
      tries++;
    end while (!last_accept && tries < 50);
    if (!last_accept) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, mr);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [W-1:0] d,
                            input logic [R-1:0] k, input logic l);
    if (obs_q.size() > idx) begin
      check({tag, "_data"}, 64'(obs_q[idx].data), 64'(d));
      check({tag, "_keep"}, 64'(obs_q[idx].keep), 64'(k));
      check({tag, "_last"}, 64'(obs_q[idx].last), 64'(l));
    end else begin
      check({tag, "_missing"}, 64'(obs_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    logic          hv;
    logic [DW-1:0] hd;
    logic          hl;
    logic [DW-1:0] out_bytes[$];
    logic          out_last[$];
    int            nk;
    int            nbad;

    tests = 0; fails = 0; stalls = 0; prev_rst = 1'b0; last_accept = 1'b0;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_tready = 1'b0;
    @(posedge clk);
    @(posedge clk);

    // Reset state: ready forced low, outputs zero.
    step(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
    idle(1, 1'b1);

    // Full word.
    obs_q.delete();
    send(8'h11, 1'b0, 1'b1); send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1); send(8'h44, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("full_count", 64'(obs_q.size()), 64'd1);
    check_word("full", 0, 32'h44332211, 4'b1111, 1'b1);

    // Short packet, then confirm the next word starts in lane 0.
    obs_q.delete();
    send(8'hA1, 1'b0, 1'b1); send(8'hA2, 1'b1, 1'b1);
    idle(2, 1'b1);
    send(8'hB1, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("short_count", 64'(obs_q.size()), 64'd2);
    check_word("short", 0, 32'h0000A2A1, 4'b0011, 1'b1);
    check_word("single", 1, 32'h000000B1, 4'b0001, 1'b1);

    // Back-to-back streaming: no stall cycle anywhere in the burst.
    obs_q.delete();
    stalls = 0;
    for (int i = 1; i <= 8; i++) send(8'(i), (i == 8) ? 1'b1 : 1'b0, 1'b1);
    idle(2, 1'b1);
    check("burst_stalls", 64'(stalls), 64'd0);
    check_word("burst0", 0, 32'h04030201, 4'b1111, 1'b0);
    check_word("burst1", 1, 32'h08070605, 4'b1111, 1'b1);

    // Backpressure: master held off for 5 cycles after the first word closes.
    obs_q.delete();
    send(8'h10, 1'b0, 1'b0); send(8'h20, 1'b0, 1'b0);
    send(8'h30, 1'b0, 1'b0); send(8'h40, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h50, 1'b0, 1'b0);
      check("bp_ready", 64'(s_tready), 64'd0);
      check("bp_hold_data", 64'(m_tdata), 64'h40302010);
      check("bp_hold_keep", 64'(m_tkeep), 64'hF);
    end
    send(8'h50, 1'b0, 1'b1); send(8'h60, 1'b0, 1'b1);
    send(8'h70, 1'b0, 1'b1); send(8'h80, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("bp_count", 64'(obs_q.size()), 64'd2);
    check_word("bp0", 0, 32'h40302010, 4'b1111, 1'b0);
    check_word("bp1", 1, 32'h80706050, 4'b1111, 1'b1);

    // Reset mid-packet discards the partial word.
    obs_q.delete();
    send(8'h55, 1'b0, 1'b1); send(8'h66, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    send(8'h77, 1'b1, 1'b1);
    idle(2, 1'b1);
    check("rstmid_count", 64'(obs_q.size()), 64'd1);
    check_word("rstmid", 0, 32'h00000077, 4'b0001, 1'b1);

    // Reset while a word is held under backpressure: that word is dropped.
    obs_q.delete();
    send(8'hC1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(2, 1'b1);
    check("rsthold_count", 64'(obs_q.size()), 64'd0);

    // Random-stall soak.
    obs_q.delete(); in_bytes.delete(); in_last.delete();
    hv = 1'b0; hd = 8'h00; hl = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 3) != 0);
        hd = 8'($urandom);
        hl = ($urandom_range(0, 4) == 0);
      end
      step(1'b0, hv, hd, hl, ($urandom_range(0, 2) != 0));
      if (last_accept) hv = 1'b0;
    end
    send(8'h5A, 1'b1, 1'b1);
    idle(3, 1'b1);
    foreach (obs_q[j]) begin
      nk = $countones(obs_q[j].keep);
      for (int i = 0; i < nk; i++) begin
        out_bytes.push_back(obs_q[j].data[i*DW +: DW]);
        out_last.push_back(obs_q[j].last && (i == nk - 1));
      end
    end
    check("soak_len", 64'(out_bytes.size()), 64'(in_bytes.size()));
    nbad = 0;
    foreach (in_bytes[i]) begin
      if (i < out_bytes.size()) begin
        if (out_bytes[i] !== in_bytes[i] || out_last[i] !== in_last[i]) nbad++;
      end
    end
    check("soak_stream", 64'(nbad), 64'd0);
    check("soak_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
